// File: rtl/ysyx_23060096_wb_pkg.sv
// Shared widths and the result-source select used by the write-back unit.
package ysyx_23060096_wb_pkg;
  localparam int WB_ADDR_WIDTH = 5;
  localparam int WB_DATA_WIDTH = 32;
  localparam int NUM_REGS      = 1 << WB_ADDR_WIDTH;

  typedef enum logic [1:0] {SRC_NONE, SRC_EXU, SRC_LSU} src_sel_e;
endpackage

// File: rtl/ysyx_23060096_scoreboard.sv
// Busy scoreboard: one bit per register, set on reserve, cleared on the
// register-file write edge, with sticky protocol-error detection.
module ysyx_23060096_scoreboard import ysyx_23060096_wb_pkg::*; #(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH
)(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  set_en,
  input  logic [ADDR_WIDTH-1:0] set_rd,
  input  logic                  clr_en,
  input  logic [ADDR_WIDTH-1:0] clr_rd,
  input  logic                  acc_en,
  input  logic [ADDR_WIDTH-1:0] acc_rd,
  input  logic [ADDR_WIDTH-1:0] chk_ra,
  input  logic [ADDR_WIDTH-1:0] chk_rb,
  input  logic [ADDR_WIDTH-1:0] chk_rd,
  output logic                  hazard_a,
  output logic                  hazard_b,
  output logic                  hazard_d,
  output logic                  err
);
  localparam int NREGS = 1 << ADDR_WIDTH;

  logic [NREGS-1:0] busy, set_vec, clr_vec;
  logic             err_waw, err_orphan;

  // x0 is never set, so busy[0] stays 0 and every check on index 0 reads clear
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en && set_rd != '0) set_vec[set_rd] = 1'b1;
    if (clr_en)                 clr_vec[clr_rd] = 1'b1;
  end

  // Re-reserving a register whose write lands on this same edge is legal
  assign err_waw    = |(set_vec & busy & ~clr_vec);
  assign err_orphan = acc_en && (acc_rd != '0) && !busy[acc_rd];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy <= '0;
      err  <= 1'b0;
    end else begin
      busy <= (busy & ~clr_vec) | set_vec;
      if (err_waw || err_orphan) err <= 1'b1;
    end
  end

  assign hazard_a = busy[chk_ra];
  assign hazard_b = busy[chk_rb];
  assign hazard_d = busy[chk_rd];
endmodule

// File: rtl/ysyx_23060096_wbu.sv
// Write-back unit: LSU-priority arbiter between EXU and LSU results feeding a
// registered register-file write port, plus retire counter and busy scoreboard.
module ysyx_23060096_wbu import ysyx_23060096_wb_pkg::*; #(
  parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int DATA_WIDTH = WB_DATA_WIDTH
)(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rsv_valid,
  input  logic [ADDR_WIDTH-1:0] rsv_rd,
  input  logic [ADDR_WIDTH-1:0] chk_ra,
  input  logic [ADDR_WIDTH-1:0] chk_rb,
  input  logic [ADDR_WIDTH-1:0] chk_rd,
  output logic                  hazard_a,
  output logic                  hazard_b,
  output logic                  hazard_d,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [31:0]           retire_cnt,
  output logic                  err
);
  src_sel_e              src;
  logic                  acc;
  logic [ADDR_WIDTH-1:0] acc_rd;
  logic [DATA_WIDTH-1:0] acc_data;

  // The register file never back-pressures, so only the EXU ever waits
  assign lsu_ready = 1'b1;
  assign exu_ready = !lsu_valid;

  always_comb begin
    src = SRC_NONE;
    if (lsu_valid)      src = SRC_LSU;
    else if (exu_valid) src = SRC_EXU;
  end

  always_comb begin
    acc      = 1'b0;
    acc_rd   = '0;
    acc_data = '0;
    case (src)
      SRC_LSU: begin acc = 1'b1; acc_rd = lsu_rd; acc_data = lsu_data; end
      SRC_EXU: begin acc = 1'b1; acc_rd = exu_rd; acc_data = exu_data; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wen        <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      retire_cnt <= '0;
    end else begin
      wen <= acc && (acc_rd != '0);
      if (acc && acc_rd != '0) begin
        waddr <= acc_rd;
        wdata <= acc_data;
      end
      if (acc) retire_cnt <= retire_cnt + 32'd1;
    end
  end

  ysyx_23060096_scoreboard #(.ADDR_WIDTH(ADDR_WIDTH)) u_sb (
    .clk      (clk),
    .rstn     (rstn),
    .set_en   (rsv_valid),
    .set_rd   (rsv_rd),
    .clr_en   (wen),
    .clr_rd   (waddr),
    .acc_en   (acc),
    .acc_rd   (acc_rd),
    .chk_ra   (chk_ra),
    .chk_rb   (chk_rb),
    .chk_rd   (chk_rd),
    .hazard_a (hazard_a),
    .hazard_b (hazard_b),
    .hazard_d (hazard_d),
    .err      (err)
  );
endmodule

// File: tb/tb_ysyx_23060096_wbu.sv
// Self-checking bench for the write-back unit: directed scenarios plus a
// randomized run against a cycle-level reference model of the spec rules.
module tb_ysyx_23060096_wbu;
  logic        clk = 1'b0;
  logic        rstn;
  logic        rsv_valid;
  logic [4:0]  rsv_rd, chk_ra, chk_rb, chk_rd;
  logic        hazard_a, hazard_b, hazard_d;
  logic        exu_valid, exu_ready, lsu_valid, lsu_ready;
  logic [4:0]  exu_rd, lsu_rd;
  logic [31:0] exu_data, lsu_data;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata, retire_cnt;
  logic        err;

  int passed = 0;
  int total  = 0;

  // reference model state
  bit          m_busy [32];
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata, m_cnt;
  logic        m_err;

  always #5 clk = ~clk;

  ysyx_23060096_wbu dut (
    .clk(clk), .rstn(rstn),
    .rsv_valid(rsv_valid), .rsv_rd(rsv_rd),
    .chk_ra(chk_ra), .chk_rb(chk_rb), .chk_rd(chk_rd),
    .hazard_a(hazard_a), .hazard_b(hazard_b), .hazard_d(hazard_d),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .retire_cnt(retire_cnt), .err(err)
  );

  // Advance one clock; the model applies the spec rules to the inputs seen at the edge.
  task automatic tick();
    bit          nb [32];
    bit          acc, nerr;
    logic [4:0]  ard;
    logic [31:0] adat;
    nb = m_busy; nerr = m_err; acc = 0; ard = 0; adat = 0;
    if (lsu_valid)      begin acc = 1; ard = lsu_rd; adat = lsu_data; end
    else if (exu_valid) begin acc = 1; ard = exu_rd; adat = exu_data; end
    if (rsv_valid && rsv_rd != 0 && m_busy[rsv_rd] && !(m_wen && m_waddr == rsv_rd)) nerr = 1;
    if (acc && ard != 0 && !m_busy[ard]) nerr = 1;
    if (m_wen) nb[m_waddr] = 0;
    if (rsv_valid && rsv_rd != 0) nb[rsv_rd] = 1;
    @(posedge clk);
    if (!rstn) begin
      foreach (m_busy[i]) m_busy[i] = 0;
      m_wen = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0; m_err = 0;
    end else begin
      m_busy = nb;
      m_err  = nerr;
      m_wen  = acc && ard != 0;
      if (m_wen) begin m_waddr = ard; m_wdata = adat; end
      if (acc) m_cnt = m_cnt + 1;
    end
    #1;
  endtask

  task automatic test_reset();
    rstn = 0; rsv_valid = 0; rsv_rd = 0; chk_ra = 0; chk_rb = 0; chk_rd = 0;
    exu_valid = 0; exu_rd = 0; exu_data = 0; lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    tick(); tick();
    total++; if (wen !== 1'b0) $display("FAIL reset_wen: got %0b want 0", wen); else passed++;
    total++; if (waddr !== 5'd0) $display("FAIL reset_waddr: got %0d want 0", waddr); else passed++;
    total++; if (wdata !== 32'd0) $display("FAIL reset_wdata: got %h want 0", wdata); else passed++;
    total++; if (retire_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d want 0", retire_cnt); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %0b want 0", err); else passed++;
    total++; if ({exu_ready, lsu_ready} !== 2'b11) $display("FAIL reset_ready: got %b want 11", {exu_ready, lsu_ready}); else passed++;
    for (int i = 0; i < 32; i++) begin
      chk_ra = 5'(i); chk_rb = 5'(i); chk_rd = 5'(i); #1;
      total++;
      if ({hazard_a, hazard_b, hazard_d} !== 3'b000)
        $display("FAIL reset_hazard[%0d]: got %b want 000", i, {hazard_a, hazard_b, hazard_d});
      else passed++;
    end
    rstn = 1; chk_ra = 0; chk_rb = 0; chk_rd = 0;
    tick();
    total++; if (wen !== 1'b0) $display("FAIL idle_wen: got %0b want 0", wen); else passed++;
  endtask

  task automatic test_single();
    chk_ra = 5; rsv_valid = 1; rsv_rd = 5;
    tick(); rsv_valid = 0;
    total++; if (hazard_a !== 1'b1) $display("FAIL single_haz_c1: got %0b want 1", hazard_a); else passed++;
    tick();
    total++; if (hazard_a !== 1'b1) $display("FAIL single_haz_c2: got %0b want 1", hazard_a); else passed++;
    tick();
    total++; if (hazard_a !== 1'b1) $display("FAIL single_haz_c3: got %0b want 1", hazard_a); else passed++;
    exu_valid = 1; exu_rd = 5; exu_data = 32'hDEADBEEF; #1;
    total++; if (exu_ready !== 1'b1) $display("FAIL single_exu_ready: got %0b want 1", exu_ready); else passed++;
    tick(); exu_valid = 0;
    total++; if (wen !== 1'b1) $display("FAIL single_wen: got %0b want 1", wen); else passed++;
    total++; if (waddr !== 5'd5) $display("FAIL single_waddr: got %0d want 5", waddr); else passed++;
    total++; if (wdata !== 32'hDEADBEEF) $display("FAIL single_wdata: got %h want deadbeef", wdata); else passed++;
    total++; if (hazard_a !== 1'b1) $display("FAIL single_haz_c4: got %0b want 1", hazard_a); else passed++;
    tick();
    total++; if (hazard_a !== 1'b0) $display("FAIL single_haz_c5: got %0b want 0", hazard_a); else passed++;
    total++; if (wen !== 1'b0) $display("FAIL single_wen_c5: got %0b want 0", wen); else passed++;
    total++; if (retire_cnt !== 32'd1) $display("FAIL single_cnt: got %0d want 1", retire_cnt); else passed++;
    total++; if (err !== 1'b0) $display("FAIL single_err: got %0b want 0", err); else passed++;
  endtask

  task automatic test_arbitration();
    logic [31:0] cnt0;
    cnt0 = m_cnt;
    rsv_valid = 1; rsv_rd = 3; tick();
    rsv_rd = 7; tick(); rsv_valid = 0;
    exu_valid = 1; exu_rd = 3; exu_data = 32'hA5A50003;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h5A5A0007; #1;
    total++; if (exu_ready !== 1'b0) $display("FAIL arb_exu_blocked: got %0b want 0", exu_ready); else passed++;
    total++; if (lsu_ready !== 1'b1) $display("FAIL arb_lsu_ready: got %0b want 1", lsu_ready); else passed++;
    tick(); lsu_valid = 0; #1;
    total++; if (exu_ready !== 1'b1) $display("FAIL arb_exu_ready2: got %0b want 1", exu_ready); else passed++;
    total++; if ({wen, waddr, wdata} !== {1'b1, 5'd7, 32'h5A5A0007})
      $display("FAIL arb_first_write: got %0b/%0d/%h want 1/7/5a5a0007", wen, waddr, wdata); else passed++;
    tick(); exu_valid = 0;
    total++; if ({wen, waddr, wdata} !== {1'b1, 5'd3, 32'hA5A50003})
      $display("FAIL arb_second_write: got %0b/%0d/%h want 1/3/a5a50003", wen, waddr, wdata); else passed++;
    tick();
    chk_ra = 3; chk_rb = 7; #1;
    total++; if (wen !== 1'b0) $display("FAIL arb_wen_idle: got %0b want 0", wen); else passed++;
    total++; if ({hazard_a, hazard_b} !== 2'b00) $display("FAIL arb_hazards: got %b want 00", {hazard_a, hazard_b}); else passed++;
    total++; if (retire_cnt !== cnt0 + 32'd2) $display("FAIL arb_cnt: got %0d want %0d", retire_cnt, cnt0 + 32'd2); else passed++;
    total++; if (err !== 1'b0) $display("FAIL arb_err: got %0b want 0", err); else passed++;
  endtask

  task automatic test_rd_zero();
    logic [31:0] cnt0;
    chk_ra = 12; rsv_valid = 1; rsv_rd = 12; tick(); rsv_valid = 0;
    cnt0 = m_cnt;
    exu_valid = 1; exu_rd = 0; exu_data = 32'h1234; tick(); exu_valid = 0;
    total++; if (wen !== 1'b0) $display("FAIL rd0_wen: got %0b want 0", wen); else passed++;
    total++; if (retire_cnt !== cnt0 + 32'd1) $display("FAIL rd0_cnt: got %0d want %0d", retire_cnt, cnt0 + 32'd1); else passed++;
    tick();
    total++; if (hazard_a !== 1'b1) $display("FAIL rd0_busy_kept: got %0b want 1", hazard_a); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rd0_err: got %0b want 0", err); else passed++;
    exu_valid = 1; exu_rd = 12; exu_data = 32'hC0FFEE12; tick(); exu_valid = 0;
    tick();
    total++; if (hazard_a !== 1'b0) $display("FAIL rd0_cleanup: got %0b want 0", hazard_a); else passed++;
  endtask

  task automatic test_waw();
    chk_ra = 9; rsv_valid = 1; rsv_rd = 9; tick(); rsv_valid = 0;
    exu_valid = 1; exu_rd = 9; exu_data = 32'h99; tick(); exu_valid = 0;
    total++; if ({wen, waddr} !== {1'b1, 5'd9}) $display("FAIL waw_write: got %0b/%0d want 1/9", wen, waddr); else passed++;
    rsv_valid = 1; rsv_rd = 9; tick(); rsv_valid = 0;
    total++; if (err !== 1'b0) $display("FAIL waw_same_edge_err: got %0b want 0", err); else passed++;
    total++; if (hazard_a !== 1'b1) $display("FAIL waw_same_edge_busy: got %0b want 1", hazard_a); else passed++;
    rsv_valid = 1; rsv_rd = 9; tick(); rsv_valid = 0;
    total++; if (err !== 1'b1) $display("FAIL waw_err_set: got %0b want 1", err); else passed++;
    tick(); tick();
    total++; if (err !== 1'b1) $display("FAIL waw_err_sticky: got %0b want 1", err); else passed++;
  endtask

  task automatic test_reset_mid();
    rsv_valid = 1; rsv_rd = 4; tick(); rsv_valid = 0;
    exu_valid = 1; exu_rd = 4; exu_data = 32'h44; tick(); exu_valid = 0;
    total++; if (wen !== 1'b1) $display("FAIL rstmid_wen_pre: got %0b want 1", wen); else passed++;
    rstn = 0; tick(); rstn = 1;
    chk_ra = 4; chk_rb = 9; #1;
    total++; if (wen !== 1'b0) $display("FAIL rstmid_wen: got %0b want 0", wen); else passed++;
    total++; if (retire_cnt !== 32'd0) $display("FAIL rstmid_cnt: got %0d want 0", retire_cnt); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rstmid_err: got %0b want 0", err); else passed++;
    total++; if ({hazard_a, hazard_b} !== 2'b00) $display("FAIL rstmid_busy: got %b want 00", {hazard_a, hazard_b}); else passed++;
  endtask

  task automatic test_random();
    bit       ea, eb, ed;
    for (int n = 0; n < 400; n++) begin
      rstn      = ($urandom % 40) != 0;
      rsv_valid = $urandom % 2;  rsv_rd = 5'($urandom % 8);
      exu_valid = $urandom % 2;  exu_rd = 5'($urandom % 8); exu_data = $urandom;
      lsu_valid = ($urandom % 3) == 0; lsu_rd = 5'($urandom % 8); lsu_data = $urandom;
      chk_ra = 5'($urandom % 8); chk_rb = 5'($urandom % 8); chk_rd = 5'($urandom);
      #1;
      ea = chk_ra != 0 && m_busy[chk_ra];
      eb = chk_rb != 0 && m_busy[chk_rb];
      ed = chk_rd != 0 && m_busy[chk_rd];
      total++;
      if ({hazard_a, hazard_b, hazard_d} !== {ea, eb, ed})
        $display("FAIL rnd_hazard[%0d]: got %b want %b", n, {hazard_a, hazard_b, hazard_d}, {ea, eb, ed});
      else passed++;
      total++;
      if (exu_ready !== !lsu_valid) $display("FAIL rnd_exu_ready[%0d]: got %0b want %0b", n, exu_ready, !lsu_valid);
      else passed++;
      tick();
      total++;
      if ({wen, waddr, wdata} !== {m_wen, m_waddr, m_wdata})
        $display("FAIL rnd_write[%0d]: got %0b/%0d/%h want %0b/%0d/%h", n, wen, waddr, wdata, m_wen, m_waddr, m_wdata);
      else passed++;
      total++;
      if ({retire_cnt, err} !== {m_cnt, m_err})
        $display("FAIL rnd_cnt_err[%0d]: got %0d/%0b want %0d/%0b", n, retire_cnt, err, m_cnt, m_err);
      else passed++;
    end
    rstn = 1; rsv_valid = 0; exu_valid = 0; lsu_valid = 0;
  endtask

  initial begin
    foreach (m_busy[i]) m_busy[i] = 0;
    m_wen = 0; m_waddr = 0; m_wdata = 0; m_cnt = 0; m_err = 0;
    test_reset();
    test_single();
    test_arbitration();
    test_rd_zero();
    test_waw();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ysyx_23060096_wbu.md
# ysyx_23060096_wbu

Write-back unit: the writer side of the register-file write port. It accepts completed results from the EXU (ALU/branch-link) and the LSU (load data) over valid/ready handshakes, arbitrates between them, and drives a registered single write port (`wen`/`waddr`/`wdata`) into the register file. It also keeps a busy scoreboard so the IDU can detect RAW/WAW hazards on registers with writes still in flight. It sits between the EXU/LSU and the register file, with a hazard side-channel to the IDU.

## Interface
- `ADDR_WIDTH`, 5, register index width; 1<<ADDR_WIDTH architectural registers
- `DATA_WIDTH`, 32, register data width
- `clk`  in  1  clock, all state updates on rising edge
- `rstn`  in  1  synchronous, active-low reset
- `rsv_valid`  in  1  IDU dispatches an instruction that will write `rsv_rd`
- `rsv_rd`  in  ADDR_WIDTH  destination register being reserved
- `chk_ra`, `chk_rb`, `chk_rd`  in  ADDR_WIDTH  IDU source/dest registers to check
- `hazard_a`, `hazard_b`, `hazard_d`  out  1  busy bit of the matching register (combinational from registered state)
- `exu_valid` / `exu_ready`  in / out  1  EXU result handshake
- `exu_rd`, `exu_data`  in  ADDR_WIDTH, DATA_WIDTH  EXU result
- `lsu_valid` / `lsu_ready`  in / out  1  LSU load-result handshake
- `lsu_rd`, `lsu_data`  in  ADDR_WIDTH, DATA_WIDTH  LSU result
- `wen`, `waddr`, `wdata`  out  1, ADDR_WIDTH, DATA_WIDTH  register-file write port, registered
- `retire_cnt`  out  32  count of accepted results (including rd=0)
- `err`  out  1  sticky protocol-error flag

## Operation
- Reset (`rstn`=0 at an edge): busy vector = 0, `wen`=0, `waddr`=0, `wdata`=0, `retire_cnt`=0, `err`=0. Any in-flight write is dropped.
- Arbitration: fixed LSU priority. `lsu_ready`=1 always. `exu_ready`=!`lsu_valid`. At most one result is accepted per cycle. The write stage never stalls because the register file always accepts.
- Accept (valid&ready, rd≠0): the next edge loads `wen`=1, `waddr`=rd, `wdata`=data.
- Accept with rd=0: `wen`=0 next cycle, no busy change, `retire_cnt` still increments.
- No accept: `wen`=0 next cycle. `waddr` and `wdata` hold their previous values.
- Scoreboard set: `rsv_valid` with `rsv_rd`≠0 sets `busy[rsv_rd]`. rd=0 is ignored.
- Scoreboard clear: `busy[waddr]` clears on the edge where `wen`=1, which is the same edge the register file captures the data.
- Simultaneous set and clear of the same register in one edge: set wins and `err` stays 0. This is the legal back-to-back case.
- Protocol errors set `err` (sticky until reset):
  - reserve of an already-busy register that is not being cleared that edge (WAW without stall);
  - an accepted result whose rd≠0 is not busy.
- `hazard_x` = `busy[chk_x]`. Always 0 for index 0.
- `retire_cnt` wraps modulo 2^32.

## Timing
- Result latency: accepted at cycle N → `wen` high during N+1 → value readable from the register file in N+2.
- Busy bit is visible as 1 from the cycle after the `rsv_valid` edge. It reads 0 from N+2 for a result accepted at N.
- No bypass: during N+1 the hazard is still 1, so the IDU stalls one extra cycle.
- EXU starvation under continuous LSU valid is permitted. The LSU never issues back-to-back indefinitely by design.

## Structure
- Package `ysyx_23060096_wb_pkg`: `ADDR_WIDTH`/`DATA_WIDTH` defaults, `NUM_REGS`, source-select enum {SRC_NONE, SRC_EXU, SRC_LSU}.
- Sub-module `ysyx_23060096_scoreboard`: busy vector, set/clear/error logic, three check ports. The top holds the arbiter, write register, and counter.

## Test plan
- Reset then idle: all outputs 0, `hazard_*`=0 for every index, `err`=0.
- Reserve x5 at cycle 0, then EXU result rd=5 data 0xDEADBEEF accepted at cycle 3:
  - `hazard_a`(x5)=1 over cycles 1–4;
  - `wen`=1, `waddr`=5, `wdata`=0xDEADBEEF at cycle 4;
  - `hazard_a`=0 at cycle 5;
  - `retire_cnt`=1.
- EXU and LSU both valid in the same cycle (rd=3 and rd=7, both reserved):
  - LSU accepted first and `exu_ready`=0;
  - EXU accepted the following cycle;
  - writes appear in order x7 then x3.
- Result to rd=0 with data 0x1234: `wen` stays 0, busy vector unchanged, `retire_cnt` increments, `err`=0.
- Reserve x9 twice with no intervening write → `err`=1 and stays 1. Reserve x9 on the same edge its write clears → `err` stays 0 and x9 stays busy.
- `rstn`=0 asserted the cycle after an accept: `wen`=0 on the following cycle, busy vector cleared, `retire_cnt`=0.
